// File: rtl/ab_grant_arbiter_if.sv
// Request/grant bundle between requesters A/B and ab_grant_arbiter.
// master = requester side, slave = arbiter side.
interface ab_grant_arbiter_if;
    logic req_a;
    logic req_b;
    logic done;
    logic gnt_a;
    logic gnt_b;
    logic busy;
    logic timeout;
    logic last_owner;

    modport master (
        output req_a, req_b, done,
        input  gnt_a, gnt_b, busy, timeout, last_owner
    );

    modport slave (
        input  req_a, req_b, done,
        output gnt_a, gnt_b, busy, timeout, last_owner
    );
endinterface

// File: rtl/ab_grant_arbiter.sv
// Two-requester round-robin arbiter with bounded hold and forced-release timeout.
// Define AB_ARB_ASSERT_EN to compile the embedded protocol assertions.
module ab_grant_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    ab_grant_arbiter_if.slave   bus
);

    // One-hot grant encoding: the state bits are the grant outputs themselves.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;
    logic                last_owner_q, last_owner_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            timeout_q    <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            timeout_q    <= timeout_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        timeout_d    = 1'b0;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                // On a tie, the requester that was not served last wins.
                if (bus.req_a && (!bus.req_b || last_owner_q)) begin
                    state_d      = GRANT_A;
                    last_owner_d = 1'b0;
                end else if (bus.req_b) begin
                    state_d      = GRANT_B;
                    last_owner_d = 1'b1;
                end
            end
            GRANT_A: begin
                if (bus.done || !bus.req_a) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GRANT_B: begin
                if (bus.done || !bus.req_b) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt_a      = state_q[0];
    assign bus.gnt_b      = state_q[1];
    assign bus.busy       = |state_q;
    assign bus.timeout    = timeout_q;
    assign bus.last_owner = last_owner_q;

`ifdef AB_ARB_ASSERT_EN
    a_mutex: assert property (@(posedge clk) disable iff (rst)
        !(bus.gnt_a && bus.gnt_b))
        $display("%0t a_mutex pass", $time);
        else $display("%0t a_mutex fail", $time);

    a_rise_a: assert property (@(posedge clk) disable iff (rst)
        $rose(bus.gnt_a) |-> $past(bus.req_a))
        $display("%0t a_rise_a pass", $time);
        else $display("%0t a_rise_a fail", $time);

    a_rise_b: assert property (@(posedge clk) disable iff (rst)
        $rose(bus.gnt_b) |-> $past(bus.req_b))
        $display("%0t a_rise_b pass", $time);
        else $display("%0t a_rise_b fail", $time);

    a_idle_gap: assert property (@(posedge clk) disable iff (rst)
        ($fell(bus.gnt_a) || $fell(bus.gnt_b)) |-> !bus.busy)
        $display("%0t a_idle_gap pass", $time);
        else $display("%0t a_idle_gap fail", $time);

    a_timeout_idle: assert property (@(posedge clk) disable iff (rst)
        bus.timeout |-> (!bus.gnt_a && !bus.gnt_b))
        $display("%0t a_timeout_idle pass", $time);
        else $display("%0t a_timeout_idle fail", $time);

    a_hold_a: assert property (@(posedge clk) disable iff (rst)
        $rose(bus.gnt_a) |-> ##[1:MAX_HOLD] !bus.gnt_a)
        $display("%0t a_hold_a pass", $time);
        else $display("%0t a_hold_a fail", $time);

    a_hold_b: assert property (@(posedge clk) disable iff (rst)
        $rose(bus.gnt_b) |-> ##[1:MAX_HOLD] !bus.gnt_b)
        $display("%0t a_hold_b pass", $time);
        else $display("%0t a_hold_b fail", $time);
`else
`endif

endmodule
